regfile_scoreboard: RTL and testbench

Parametrised general-purpose register file for the MIPS-based datapath, with two combinational read ports, one clocked write port, and a per-register pending (scoreboard) bit. Register 0 reads as zero. It replaces the fixed 16 x 16-bit register bank built from discrete flip-flops and muxes. The pending bits let the decode stage stall on read-after-write hazards from multi-cycle producers.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_read_port.sv | 60 ++++++
 rtl/regfile_scoreboard.sv | 108 ++++++++++
 tb/tb_regfile_scoreboard.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared constants and types for the general-purpose register file with
//   per-register scoreboard bits.
//
//   REGFILE_DATA_W : default register width in bits
//   REGFILE_ADDR_W : default register index width (2**ADDR_W registers)
//   reg_idx_t      : register index at the default geometry
//   reg_word_t     : register word at the default geometry
package regfile_pkg;

   localparam int REGFILE_DATA_W = 16;
   localparam int REGFILE_ADDR_W = 4;

   typedef logic [REGFILE_ADDR_W-1:0] reg_idx_t;
   typedef logic [REGFILE_DATA_W-1:0] reg_word_t;

endpackage : regfile_pkg

// File: rtl/regfile_read_port.sv
// regfile_read_port
//   One combinational read port of the register file. Selects a word and its
//   pending bit by index, forces register 0 to read as zero / ready, and,
//   when REGFILE_BYPASS_EN is defined, forwards same-cycle write-back data.
//
//   Optional feature macro: REGFILE_BYPASS_EN
//
//   Ports:
//     regs       in   register array (2**ADDR_W words of DATA_W bits)
//     pending    in   per-register pending vector
//     raddr      in   index to read
//     we         in   write-back strobe              (bypass build only)
//     waddr      in   write-back index               (bypass build only)
//     wdata      in   write-back data                (bypass build only)
//     issue      in   same-cycle claim strobe        (bypass build only)
//     issue_addr in   same-cycle claim index         (bypass build only)
//     rdata      out  selected register value
//     rdy        out  1 when the selected register is not pending
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int DATA_W = REGFILE_DATA_W,
   parameter int ADDR_W = REGFILE_ADDR_W
) (
   input  logic [DATA_W-1:0]     regs [2**ADDR_W],
   input  logic [2**ADDR_W-1:0]  pending,
   input  logic [ADDR_W-1:0]     raddr,
`ifdef REGFILE_BYPASS_EN
   input  logic                  we,
   input  logic [ADDR_W-1:0]     waddr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic                  issue,
   input  logic [ADDR_W-1:0]     issue_addr,
`endif
   output logic [DATA_W-1:0]     rdata,
   output logic                  rdy
);

   always_comb begin
      // NOTE: every output gets a value before any branch so no latch is inferred.
      rdata = regs[raddr];
      rdy   = ~pending[raddr];

`ifdef REGFILE_BYPASS_EN
      // A write landing this cycle completes the producer, unless a newer
      // producer claims the same register on the same edge.
      if (we && (waddr != '0) && (raddr == waddr)) begin
         rdata = wdata;
         rdy   = ~(issue && (issue_addr == waddr));
      end
`endif

      // Register 0 is hard-wired: zero data, never pending.
      if (raddr == '0) begin
         rdata = '0;
         rdy   = 1'b1;
      end
   end

endmodule : regfile_read_port

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Parametrised register file with two combinational read ports, one clocked
//   write-back port and a pending (scoreboard) bit per register. Register 0
//   reads as zero and is never pending. The decode stage uses rdy_a/rdy_b to
//   stall on read-after-write hazards from multi-cycle producers.
//
//   Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-back forwarding
//   on the read ports; state updates are unaffected).
//
//   Ports:
//     clk         in   rising-edge clock
//     clr         in   asynchronous active-high reset (clears regs and pending)
//     we          in   write-back enable
//     waddr       in   write-back index
//     wdata       in   write-back data
//     issue       in   claim a destination register (set pending)
//     issue_addr  in   index being claimed
//     raddr_a/b   in   read port indices
//     rdata_a/b   out  read port data
//     rdy_a/b     out  read port register not pending
//     any_pending out  OR of all pending bits (stored state only)
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int DATA_W = REGFILE_DATA_W,
   parameter int ADDR_W = REGFILE_ADDR_W
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              issue,
   input  logic [ADDR_W-1:0] issue_addr,
   input  logic [ADDR_W-1:0] raddr_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b,
   output logic              rdy_a,
   output logic              rdy_b,
   output logic              any_pending
);

   localparam int NUM_REGS = 2**ADDR_W;

   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic [NUM_REGS-1:0] pending;

   // NOTE: the register array is reset along with the pending bits because the
   // datapath relies on every register reading zero right after clr.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
         pending <= '0;
      end else begin
         if (we && (waddr != '0)) begin
            regs[waddr]    <= wdata;
            pending[waddr] <= 1'b0;
         end
         // Placed after the write so that, on the same index, the claim from a
         // newer producer overrides the clear from the completing one.
         if (issue && (issue_addr != '0)) begin
            pending[issue_addr] <= 1'b1;
         end
      end
   end

   assign any_pending = |pending;

   regfile_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_port_a (
      .regs       (regs),
      .pending    (pending),
      .raddr      (raddr_a),
`ifdef REGFILE_BYPASS_EN
      .we         (we),
      .waddr      (waddr),
      .wdata      (wdata),
      .issue      (issue),
      .issue_addr (issue_addr),
`endif
      .rdata      (rdata_a),
      .rdy        (rdy_a)
   );

   regfile_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_port_b (
      .regs       (regs),
      .pending    (pending),
      .raddr      (raddr_b),
`ifdef REGFILE_BYPASS_EN
      .we         (we),
      .waddr      (waddr),
      .wdata      (wdata),
      .issue      (issue),
      .issue_addr (issue_addr),
`endif
      .rdata      (rdata_b),
      .rdy        (rdy_b)
   );

endmodule : regfile_scoreboard

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard
//   Self-checking bench for regfile_scoreboard: reset and mid-cycle clear,
//   a table of write/issue/read vectors, same-cycle bypass behaviour (both
//   builds), a randomized run against an array-based reference model, and a
//   32-bit / 32-register instance.
module tb_regfile_scoreboard;

   logic clk;
   logic clr;

   // default geometry instance
   logic        we;
   logic [3:0]  waddr;
   logic [15:0] wdata;
   logic        issue;
   logic [3:0]  issue_addr;
   logic [3:0]  raddr_a;
   logic [3:0]  raddr_b;
   logic [15:0] rdata_a;
   logic [15:0] rdata_b;
   logic        rdy_a;
   logic        rdy_b;
   logic        any_pending;

   // wide instance
   logic        w_we;
   logic [4:0]  w_waddr;
   logic [31:0] w_wdata;
   logic        w_issue;
   logic [4:0]  w_issue_addr;
   logic [4:0]  w_raddr_a;
   logic [4:0]  w_raddr_b;
   logic [31:0] w_rdata_a;
   logic [31:0] w_rdata_b;
   logic        w_rdy_a;
   logic        w_rdy_b;
   logic        w_any_pending;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [15:0] m_regs [16];
   logic        m_pend [16];

   regfile_scoreboard dut (
      .clk         (clk),
      .clr         (clr),
      .we          (we),
      .waddr       (waddr),
      .wdata       (wdata),
      .issue       (issue),
      .issue_addr  (issue_addr),
      .raddr_a     (raddr_a),
      .raddr_b     (raddr_b),
      .rdata_a     (rdata_a),
      .rdata_b     (rdata_b),
      .rdy_a       (rdy_a),
      .rdy_b       (rdy_b),
      .any_pending (any_pending)
   );

   regfile_scoreboard #(.DATA_W(32), .ADDR_W(5)) dut_wide (
      .clk         (clk),
      .clr         (clr),
      .we          (w_we),
      .waddr       (w_waddr),
      .wdata       (w_wdata),
      .issue       (w_issue),
      .issue_addr  (w_issue_addr),
      .raddr_a     (w_raddr_a),
      .raddr_b     (w_raddr_b),
      .rdata_a     (w_rdata_a),
      .rdata_b     (w_rdata_b),
      .rdy_a       (w_rdy_a),
      .rdy_b       (w_rdy_b),
      .any_pending (w_any_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_regs[i] = '0;
         m_pend[i] = 1'b0;
      end
   endtask

   // Reference read: stored value, zero register, optional forwarding.
   task automatic model_read(input logic [3:0] ra, output logic [15:0] d, output logic r);
      d = m_regs[ra];
      r = !m_pend[ra];
`ifdef REGFILE_BYPASS_EN
      if (we && waddr != 0 && ra == waddr) begin
         d = wdata;
         r = !(issue && issue_addr == waddr);
      end
`endif
      if (ra == 0) begin
         d = '0;
         r = 1'b1;
      end
   endtask

   function automatic logic model_any();
      logic a = 1'b0;
      for (int i = 0; i < 16; i++) a = a | m_pend[i];
      return a;
   endfunction

   // Advance one clock edge, updating the model with the inputs sampled there.
   task automatic tick();
      @(posedge clk);
      if (clr) begin
         model_reset();
      end else begin
         if (we && waddr != 0) begin
            m_regs[waddr] = wdata;
            m_pend[waddr] = 1'b0;
         end
         if (issue && issue_addr != 0) m_pend[issue_addr] = 1'b1;
      end
      #1;
   endtask

   task automatic idle();
      we = 0; waddr = 0; wdata = 0; issue = 0; issue_addr = 0;
      w_we = 0; w_waddr = 0; w_wdata = 0; w_issue = 0; w_issue_addr = 0;
   endtask

   task automatic check_model(input string tag);
      logic [15:0] da, db;
      logic        ra, rb;
      model_read(raddr_a, da, ra);
      model_read(raddr_b, db, rb);
      check({tag, " rdata_a"}, 32'(rdata_a), 32'(da));
      check({tag, " rdata_b"}, 32'(rdata_b), 32'(db));
      check({tag, " rdy_a"}, 32'(rdy_a), 32'(ra));
      check({tag, " rdy_b"}, 32'(rdy_b), 32'(rb));
      check({tag, " any_pending"}, 32'(any_pending), 32'(model_any()));
   endtask

   typedef struct {
      logic        we;
      logic [3:0]  waddr;
      logic [15:0] wdata;
      logic        issue;
      logic [3:0]  issue_addr;
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic [15:0] exp_da;
      logic        exp_ra;
      logic [15:0] exp_db;
      logic        exp_rb;
      logic        exp_any;
   } vec_t;

   vec_t vecs [11];

   initial begin
      // Each vector strobes for one edge; outputs are checked afterwards with
      // strobes released, so the expectations are stored state only.
      vecs[0]  = '{1, 3,  16'hBEEF, 0, 0,  3,  3,  16'hBEEF, 1, 16'hBEEF, 1, 0};
      vecs[1]  = '{1, 0,  16'hFFFF, 0, 0,  0,  0,  16'h0000, 1, 16'h0000, 1, 0};
      vecs[2]  = '{0, 0,  16'h0000, 1, 9,  9,  3,  16'h0000, 0, 16'hBEEF, 1, 1};
      vecs[3]  = '{1, 9,  16'h00AA, 0, 0,  9,  9,  16'h00AA, 1, 16'h00AA, 1, 0};
      vecs[4]  = '{1, 4,  16'h5555, 1, 4,  4,  3,  16'h5555, 0, 16'hBEEF, 1, 1};
      vecs[5]  = '{0, 0,  16'h0000, 1, 0,  0,  4,  16'h0000, 1, 16'h5555, 0, 1};
      vecs[6]  = '{1, 7,  16'h1111, 1, 8,  7,  8,  16'h1111, 1, 16'h0000, 0, 1};
      vecs[7]  = '{1, 4,  16'h2222, 0, 0,  4,  8,  16'h2222, 1, 16'h0000, 0, 1};
      vecs[8]  = '{1, 8,  16'h3333, 0, 0,  8,  4,  16'h3333, 1, 16'h2222, 1, 0};
      vecs[9]  = '{1, 15, 16'hABCD, 1, 15, 15, 15, 16'hABCD, 0, 16'hABCD, 0, 1};
      vecs[10] = '{1, 15, 16'h0F0F, 0, 0,  15, 1,  16'h0F0F, 1, 16'h0000, 1, 0};

      idle();
      raddr_a = 4'd5; raddr_b = 4'd7;
      w_raddr_a = 0; w_raddr_b = 0;
      model_reset();

      // ---- reset state ----
      clr = 1'b1;
      #3;
      check("reset rdata_a", 32'(rdata_a), 32'h0);
      check("reset rdy_b", 32'(rdy_b), 32'h1);
      check("reset any_pending", 32'(any_pending), 32'h0);
      tick();
      tick();
      @(negedge clk);
      clr = 1'b0;
      tick();

      // ---- table vectors ----
      for (int i = 0; i < 11; i++) begin
         we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
         issue = vecs[i].issue; issue_addr = vecs[i].issue_addr;
         raddr_a = vecs[i].ra; raddr_b = vecs[i].rb;
         tick();
         idle();
         #1;
         check($sformatf("vec%0d rdata_a", i), 32'(rdata_a), 32'(vecs[i].exp_da));
         check($sformatf("vec%0d rdy_a", i), 32'(rdy_a), 32'(vecs[i].exp_ra));
         check($sformatf("vec%0d rdata_b", i), 32'(rdata_b), 32'(vecs[i].exp_db));
         check($sformatf("vec%0d rdy_b", i), 32'(rdy_b), 32'(vecs[i].exp_rb));
         check($sformatf("vec%0d any_pending", i), 32'(any_pending), 32'(vecs[i].exp_any));
      end

      // ---- asynchronous clear mid-cycle ----
      we = 1; waddr = 5; wdata = 16'h1234; issue = 1; issue_addr = 7;
      raddr_a = 5; raddr_b = 7;
      tick();
      idle();
      #1;
      check("preclr rdata_a", 32'(rdata_a), 32'h1234);
      check("preclr rdy_b", 32'(rdy_b), 32'h0);
      #1;
      clr = 1'b1;
      #1;
      check("midclr rdata_a", 32'(rdata_a), 32'h0);
      check("midclr rdy_b", 32'(rdy_b), 32'h1);
      check("midclr any_pending", 32'(any_pending), 32'h0);
      model_reset();
      // edges ignored while clr is high
      we = 1; waddr = 5; wdata = 16'h9999; issue = 1; issue_addr = 7;
      tick();
      idle();
      #1;
      check("clrhold rdata_a", 32'(rdata_a), 32'h0);
      check("clrhold rdy_b", 32'(rdy_b), 32'h1);
      @(negedge clk);
      clr = 1'b0;
      tick();

      // ---- same-cycle write/read (bypass option) ----
      we = 1; waddr = 6; wdata = 16'h0101; raddr_a = 6; raddr_b = 0;
      tick();
      we = 1; waddr = 6; wdata = 16'hCAFE;
      #1;
`ifdef REGFILE_BYPASS_EN
      check("bypass rdata_a", 32'(rdata_a), 32'hCAFE);
`else
      check("nobypass rdata_a", 32'(rdata_a), 32'h0101);
`endif
      check("bypass rdy_a", 32'(rdy_a), 32'h1);
      tick();
      idle();
      #1;
      check("after edge rdata_a", 32'(rdata_a), 32'hCAFE);
      // write plus claim of the same register in one cycle
      we = 1; waddr = 6; wdata = 16'h7777; issue = 1; issue_addr = 6;
      #1;
`ifdef REGFILE_BYPASS_EN
      check("bypass+issue rdata_a", 32'(rdata_a), 32'h7777);
      check("bypass+issue rdy_a", 32'(rdy_a), 32'h0);
`else
      check("nobypass+issue rdata_a", 32'(rdata_a), 32'hCAFE);
      check("nobypass+issue rdy_a", 32'(rdy_a), 32'h1);
`endif
      check("bypass any_pending", 32'(any_pending), 32'h0);
      tick();
      idle();
      #1;
      check("post issue rdata_a", 32'(rdata_a), 32'h7777);
      check("post issue rdy_a", 32'(rdy_a), 32'h0);

      // ---- randomized run against the model ----
      for (int n = 0; n < 400; n++) begin
         we         = 1'($urandom_range(0, 1));
         waddr      = 4'($urandom_range(0, 15));
         wdata      = 16'($urandom);
         issue      = ($urandom_range(0, 3) == 0);
         issue_addr = 4'($urandom_range(0, 15));
         raddr_a    = 4'($urandom_range(0, 15));
         // bias port B toward the write index to exercise forwarding
         raddr_b    = ($urandom_range(0, 1) == 1) ? waddr : 4'($urandom_range(0, 15));
         #1;
         check_model($sformatf("rand%0d", n));
         tick();
      end
      idle();

      // ---- wide instance: 32-bit data, 32 registers ----
      w_we = 1; w_waddr = 5'd1; w_wdata = 32'hDEADBEEF;
      tick();
      w_waddr = 5'd31;
      tick();
      w_waddr = 5'd0; w_wdata = 32'hFFFFFFFF;
      tick();
      w_we = 0; w_issue = 1; w_issue_addr = 5'd31;
      tick();
      idle();
      w_raddr_a = 5'd1; w_raddr_b = 5'd31;
      #1;
      check("wide rdata_a r1", w_rdata_a, 32'hDEADBEEF);
      check("wide rdata_b r31", w_rdata_b, 32'hDEADBEEF);
      check("wide rdy_b r31", 32'(w_rdy_b), 32'h0);
      check("wide any_pending", 32'(w_any_pending), 32'h1);
      w_raddr_a = 5'd0;
      #1;
      check("wide rdata_a r0", w_rdata_a, 32'h0);
      check("wide rdy_a r0", 32'(w_rdy_a), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_regfile_scoreboard
